// File: rtl/instr_fetch.sv
// Fetch stage: single-outstanding req/ack instruction read feeding a small {pc, instr} FIFO.
// Halts with a fault code on a misaligned PC or a memory timeout; flush discards buffered and in-flight work.
module instr_fetch #(
  parameter int BUF_DEPTH = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] pc,
  output logic        pc_advance,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        id_ready,
  output logic        fault,
  output logic [1:0]  fault_code
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, FAULT} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_t                 state;
  entry_t [BUF_DEPTH-1:0] fifo;
  entry_t                 head;
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [CW-1:0]          count;
  logic [TW-1:0]          tcnt;
  logic                   drop;
  logic                   push, pop, issue;

  assign instr_valid = (count != '0);
  assign head        = fifo[rd_ptr];
  assign instr       = instr_valid ? head.data : '0;
  assign instr_pc    = instr_valid ? head.pc   : '0;

  // Flush beats any same-cycle pop, push or issue.
  assign pop   = instr_valid && id_ready && !flush;
  assign push  = (state == WAIT) && mem_ack && !drop && !flush;
  // pc_advance high means the PC has not stepped yet, so pc is stale this edge.
  assign issue = (state == IDLE) && !flush && (pc[1:0] == 2'b00) &&
                 (count < CW'(BUF_DEPTH)) && !pc_advance;

  always_ff @(posedge CLK) begin
    if (push) fifo[wr_ptr] <= {mem_addr, mem_rdata};
  end

  always_ff @(posedge CLK) begin
    if (!RESET || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      pc_advance <= 1'b0;
      drop       <= 1'b0;
      tcnt       <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      pc_advance <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && pc[1:0] != 2'b00) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= 2'b01;
          end else if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
            tcnt     <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (flush) drop <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            // A flushed request completes silently and retires the drop flag.
            if (drop || flush) drop <= 1'b0;
            else               pc_advance <= 1'b1;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            mem_req    <= 1'b0;
            drop       <= 1'b0;
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= 2'b10;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        FAULT: begin
          if (flush) begin
            state      <= IDLE;
            fault      <= 1'b0;
            fault_code <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run scored against an
// in-order instruction stream model (PC steps by 4, memory content is a hash of the address).
module tb_instr_fetch;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_advance;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        id_ready = 1'b0;
  logic        fault;
  logic [1:0]  fault_code;

  instr_fetch #(.BUF_DEPTH(2), .TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET), .pc(pc), .pc_advance(pc_advance), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .id_ready(id_ready),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 CLK = ~CLK;

  int          n_chk = 0, n_pass = 0;
  bit          auto_pc = 0, mem_en = 0, force_ack = 0, use_fixed = 0, sb_en = 0, rand_mode = 0;
  int          ack_lat = 0, lat_cnt = 0, adv_cnt = 0, vld_cnt = 0, pops = 0, n = 0;
  logic [31:0] fixed_data = '0, exp_pc = '0;
  logic        prev_req = 1'b0;
  logic [31:0] issued[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  // One clock: drive at negedge (PC model, memory model, scoreboard), observe 1ns after posedge.
  task automatic cyc();
    @(negedge CLK);
    if (rand_mode) begin
      id_ready = 1'($urandom_range(0, 1));
      flush    = ($urandom_range(0, 24) == 0);
      if (!mem_req) ack_lat = $urandom_range(0, 3);
    end
    if (auto_pc && pc_advance) pc = pc + 32'd4;
    if (rand_mode && flush) begin
      pc     = 32'($urandom_range(0, 1023)) << 2;
      exp_pc = pc;
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
    end else if (mem_req && mem_en) begin
      if (lat_cnt >= ack_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = use_fixed ? fixed_data : memf(mem_addr);
        lat_cnt   = 0;
      end else lat_cnt++;
    end else lat_cnt = 0;
    if (sb_en && instr_valid && id_ready && !flush) begin
      chk("pop_pc", instr_pc, exp_pc);
      chk("pop_data", instr, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    @(posedge CLK);
    #1;
    if (pc_advance) adv_cnt++;
    if (instr_valid) vld_cnt++;
    if (mem_req && !prev_req) begin
      issued.push_back(mem_addr);
      chk("issue_addr", mem_addr, pc);
    end
    prev_req = mem_req;
    if (!instr_valid) begin
      chk("empty_instr", instr, 32'd0);
      chk("empty_ipc", instr_pc, 32'd0);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b0; flush = 1'b0; force_ack = 1'b0; mem_en = 0; rand_mode = 0;
    sb_en = 0; use_fixed = 0; auto_pc = 0; id_ready = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic chk_reset_outs(input string p);
    chk({p, "_req"}, mem_req, 32'd0);
    chk({p, "_addr"}, mem_addr, 32'd0);
    chk({p, "_adv"}, pc_advance, 32'd0);
    chk({p, "_vld"}, instr_valid, 32'd0);
    chk({p, "_instr"}, instr, 32'd0);
    chk({p, "_ipc"}, instr_pc, 32'd0);
    chk({p, "_fault"}, fault, 32'd0);
    chk({p, "_code"}, fault_code, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk_reset_outs("rst");

    // Single fetch
    pc = 32'h100; id_ready = 1'b1; mem_en = 1; ack_lat = 0; auto_pc = 1;
    use_fixed = 1; fixed_data = 32'hDEADBEEF; adv_cnt = 0; vld_cnt = 0;
    RESET = 1'b1;
    cyc();
    chk("t1_req", mem_req, 32'd1);
    chk("t1_addr", mem_addr, 32'h100);
    cyc();
    chk("t1_adv", pc_advance, 32'd1);
    chk("t1_vld", instr_valid, 32'd1);
    chk("t1_instr", instr, 32'hDEADBEEF);
    chk("t1_ipc", instr_pc, 32'h100);
    chk("t1_req_lo", mem_req, 32'd0);
    mem_en = 0;
    cyc();
    chk("t1_adv_lo", pc_advance, 32'd0);
    chk("t1_vld_lo", instr_valid, 32'd0);
    cyc();
    chk("t1_next_req", mem_req, 32'd1);
    chk("t1_next_addr", mem_addr, 32'h104);
    chk("t1_adv_cnt", adv_cnt, 32'd1);
    chk("t1_vld_cnt", vld_cnt, 32'd1);

    // Back-pressure
    do_reset();
    pc = '0; auto_pc = 1; mem_en = 1; ack_lat = 0; issued.delete();
    RESET = 1'b1;
    repeat (20) cyc();
    chk("bp_nfetch", issued.size(), 32'd2);
    if (issued.size() == 2) begin
      chk("bp_a0", issued[0], 32'h0);
      chk("bp_a1", issued[1], 32'h4);
    end
    chk("bp_req", mem_req, 32'd0);
    chk("bp_pc", pc, 32'h8);
    chk("bp_head0", instr_pc, 32'h0);
    chk("bp_data0", instr, memf(32'h0));
    id_ready = 1'b1;
    cyc();
    chk("bp_head1", instr_pc, 32'h4);
    chk("bp_data1", instr, memf(32'h4));
    issued.delete();
    repeat (4) cyc();
    chk("bp_resume", (issued.size() > 0) ? issued[0] : 32'hFFFFFFFF, 32'h8);

    // Flush during WAIT
    do_reset();
    pc = 32'h20; id_ready = 1'b1; mem_en = 1; ack_lat = 3;
    RESET = 1'b1;
    cyc();
    chk("fl_req", mem_req, 32'd1);
    chk("fl_addr", mem_addr, 32'h20);
    adv_cnt = 0; vld_cnt = 0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("fl_vld", instr_valid, 32'd0);
    chk("fl_req_hold", mem_req, 32'd1);
    n = 0;
    while (mem_req && n < 10) begin cyc(); n++; end
    chk("fl_ack_seen", mem_req, 32'd0);
    pc = 32'h200;
    cyc();
    chk("fl_redir_req", mem_req, 32'd1);
    chk("fl_redir_addr", mem_addr, 32'h200);
    chk("fl_adv_cnt", adv_cnt, 32'd0);
    chk("fl_vld_cnt", vld_cnt, 32'd0);

    // Misaligned PC
    do_reset();
    pc = 32'h102; issued.delete();
    RESET = 1'b1;
    cyc();
    chk("mis_req", mem_req, 32'd0);
    chk("mis_fault", fault, 32'd1);
    chk("mis_code", fault_code, 32'd1);
    pc = 32'h104;
    repeat (2) cyc();
    chk("mis_hold", fault, 32'd1);
    chk("mis_noreq", issued.size(), 32'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("mis_clr", fault, 32'd0);
    chk("mis_clr_code", fault_code, 32'd0);
    chk("mis_req_fl", mem_req, 32'd0);
    cyc();
    chk("mis_issue", mem_req, 32'd1);
    chk("mis_addr", mem_addr, 32'h104);

    // Timeout
    do_reset();
    pc = 32'h40;
    RESET = 1'b1;
    cyc();
    chk("to_req", mem_req, 32'd1);
    repeat (15) cyc();
    chk("to_req15", mem_req, 32'd1);
    chk("to_nofault", fault, 32'd0);
    cyc();
    chk("to_drop", mem_req, 32'd0);
    chk("to_fault", fault, 32'd1);
    chk("to_code", fault_code, 32'd2);
    adv_cnt = 0; vld_cnt = 0; force_ack = 1'b1;
    repeat (2) cyc();
    force_ack = 1'b0;
    chk("to_late_code", fault_code, 32'd2);
    chk("to_late_adv", adv_cnt, 32'd0);
    chk("to_late_vld", vld_cnt, 32'd0);

    // Reset in WAIT with one entry buffered
    do_reset();
    pc = '0; auto_pc = 1; mem_en = 1; ack_lat = 0;
    RESET = 1'b1;
    n = 0;
    while (!instr_valid && n < 10) begin cyc(); n++; end
    mem_en = 0;
    n = 0;
    while (!mem_req && n < 10) begin cyc(); n++; end
    chk("rm_vld", instr_valid, 32'd1);
    chk("rm_req", mem_req, 32'd1);
    RESET = 1'b0;
    cyc();
    chk_reset_outs("rm");
    RESET = 1'b1; flush = 1'b1; force_ack = 1'b1;
    cyc();
    flush = 1'b0; force_ack = 1'b0;
    chk("rm_late_vld", instr_valid, 32'd0);
    chk("rm_late_adv", pc_advance, 32'd0);
    chk("rm_late_req", mem_req, 32'd0);

    // Randomized run: ack latency, back-pressure and flush redirects
    do_reset();
    pc = '0; exp_pc = '0; auto_pc = 1; mem_en = 1; pops = 0;
    RESET = 1'b1;
    sb_en = 1; rand_mode = 1;
    repeat (600) cyc();
    rand_mode = 0; sb_en = 0; flush = 1'b0;
    chk("rand_progress", 32'(pops > 40), 32'd1);
    chk("rand_fault", fault, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
